// File: rtl/ram.sv
// Single-port-address synchronous RAM: one read and/or one write per cycle,
// registered read data with read-before-write, async clear of the output register only.
module ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              rd,
  input  logic              wr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("ram: DEPTH exceeds the address space of ADDR_W bits");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;

  // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
  assign in_range_c = {1'b0, addr} < CMP_W'(DEPTH);
  assign idx_c      = IDX_W'(addr);

  // Memory is never cleared; reset only blocks accesses and zeroes data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      if (wr && in_range_c) begin
        mem[idx_c] <= data_in;
      end
      if (rd) begin
        data_out <= in_range_c ? mem[idx_c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram.sv
// Directed + randomized bench for ram against an array-based reference model.
module tb_ram;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned D1 = 1024;
  localparam int unsigned D2 = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr, addr2;
  logic [DW-1:0] data_in, data_in2;
  logic [DW-1:0] data_out, data_out2;
  logic          rd, wr, rd2, wr2;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] model [D1];
  logic [DW-1:0] exp_out;

  always #5 clk = ~clk;

  ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .rd(rd), .wr(wr)
  );

  ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D2)) dut_small (
    .clk(clk), .rst_n(rst_n), .addr(addr2), .data_in(data_in2),
    .data_out(data_out2), .rd(rd2), .wr(wr2)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a, input string tag);
    rd = 1'b1; wr = 1'b0; addr = AW'(a);
    tick();
    rd = 1'b0;
    check(tag, data_out, model[a]);
  endtask

  initial begin
    int a;
    logic do_rd, do_wr;
    logic [DW-1:0] d;

    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; data_in2 = '0;
    #3;
    check("reset_out", data_out, '0);
    check("reset_out_small", data_out2, '0);
    tick();
    #3 rst_n = 1'b1;
    tick();

    // Fill: mem[k] = (2k) % 256
    for (int k = 0; k < int'(D1); k++) begin
      wr = 1'b1; addr = AW'(k); data_in = DW'((2 * k) % 256);
      model[k] = DW'((2 * k) % 256);
      tick();
    end
    wr = 1'b0;

    do_read(5, "fill_a5");
    check("fill_a5_const", data_out, 32'd10);
    do_read(200, "fill_a200");
    check("fill_a200_const", data_out, 32'd144);
    do_read(1023, "fill_a1023");
    check("fill_a1023_const", data_out, 32'd254);
    do_read(0, "fill_a0");
    check("fill_a0_const", data_out, 32'd0);

    // Hold: rd low keeps the last read value despite address change
    do_read(5, "hold_setup");
    addr = AW'(200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", data_out, 32'd10);
    end

    // Read-before-write on the same address
    rd = 1'b1; wr = 1'b1; addr = AW'(7); data_in = 32'hDEADBEEF;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rbw_old", data_out, 32'd14);
    model[7] = 32'hDEADBEEF;
    do_read(7, "rbw_new");

    // Async reset mid-cycle with an attempted write that must be ignored
    #2 rst_n = 1'b0;
    #1 check("async_reset", data_out, '0);
    rd = 1'b1; wr = 1'b1; addr = AW'(200); data_in = 32'h000000FF;
    tick();
    check("reset_hold", data_out, '0);
    tick();
    rd = 1'b0; wr = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    do_read(200, "post_reset_a200");
    check("post_reset_a200_const", data_out, 32'd144);

    // Random reads
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, D1 - 1));
      do_read(a, "rand_read");
    end

    // Random mixed traffic with read-before-write semantics from the model
    exp_out = data_out;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, D1 - 1));
      do_rd = 1'($urandom_range(0, 1));
      do_wr = 1'($urandom_range(0, 1));
      d = $urandom;
      rd = do_rd; wr = do_wr; addr = AW'(a); data_in = d;
      if (do_rd) exp_out = model[a];
      if (do_wr) model[a] = d;
      tick();
      check("rand_mixed", data_out, exp_out);
    end
    rd = 1'b0; wr = 1'b0;

    // Smaller-depth instance: in-range works, out-of-range write ignored and reads 0
    wr2 = 1'b1; addr2 = AW'(999); data_in2 = 32'h12345678;
    tick();
    wr2 = 1'b0; rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    check("small_a999", data_out2, 32'h12345678);
    wr2 = 1'b1; addr2 = AW'(1010); data_in2 = 32'hAAAA5555;
    tick();
    wr2 = 1'b0; rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    check("small_oor_1010", data_out2, '0);
    addr2 = AW'(999); rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    check("small_a999_intact", data_out2, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001: Parameter ADDR_W, default 10, SHALL set the address width in bits.
REQ-002: Parameter DATA_W, default 32, SHALL set the word width in bits.
REQ-003: Parameter DEPTH, default 1024, SHALL set the number of words, and SHALL be no greater than 2^ADDR_W.
REQ-004: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005: rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006: addr  input  ADDR_W  SHALL carry the word address for both read and write.
REQ-007: data_in  input  DATA_W  SHALL carry the write data.
REQ-008: data_out  output  DATA_W  SHALL carry the registered read data.
REQ-009: rd  input  1  SHALL be the read enable, active-high.
REQ-010: wr  input  1  SHALL be the write enable, active-high.

Function
REQ-011: Storage SHALL be DEPTH words of DATA_W bits each.
REQ-012: On a rising clk edge with wr=1 and addr<DEPTH, mem[addr] SHALL take the value of data_in.
REQ-013: On a rising clk edge with rd=1 and addr<DEPTH, data_out SHALL load mem[addr]; read latency is 1 cycle.
REQ-014: With rd=0, data_out SHALL hold its previous value.
REQ-015: With rd=0 and wr=0, memory contents and data_out SHALL be unchanged.
REQ-016: With rd=1 and wr=1 on the same edge and the same address, data_out SHALL return the old contents (read-before-write), and the new value SHALL be stored.
REQ-017: With rd=1 and wr=1 on the same edge and different addresses, both operations SHALL complete independently.
REQ-018: A write with addr>=DEPTH SHALL be ignored; a read with addr>=DEPTH SHALL load 0 into data_out.
REQ-019: Address decode SHALL use exactly ADDR_W bits, with no wrap-around within DEPTH.
REQ-020: A location never written SHALL read as an undefined value; behaviour is defined only after a write.
REQ-021: The RAM SHALL have no handshake and no busy state; it accepts one read and/or one write every cycle.

Reset
REQ-022: While rst_n=0, data_out SHALL be 0 immediately, without waiting for a clock edge.
REQ-023: Reset SHALL NOT clear memory contents.
REQ-024: Writes and reads asserted while rst_n=0 SHALL be ignored.
REQ-025: Normal operation SHALL resume on the first rising clk edge after rst_n deasserts.
REQ-026: Reset asserted in the middle of a sequence SHALL leave previously written words intact and readable after reset is released.

Verification
REQ-027: Fill scenario:
- Stimulus: wr=1, rd=0, one write per cycle of data_in=(2k)%256 at addr=k for k=0..1023, then rd=1.
- Required response: addr 5 -> data_out=10; addr 200 -> 144; addr 1023 -> 254; addr 0 -> 0, each one cycle after the read edge.
REQ-028: Hold scenario:
- Stimulus: read addr 5 (data_out=10), then rd=0 for 3 cycles with addr changed to 200.
- Required response: data_out stays 10.
REQ-029: Read-before-write scenario:
- Stimulus: mem[7]=14; in one cycle rd=1, wr=1, addr=7, data_in=0xDEADBEEF.
- Required response: data_out=14; the next read of addr 7 returns 0xDEADBEEF.
REQ-030: Reset scenario:
- Stimulus: after the fill, assert rst_n=0 asynchronously between clock edges, then release it and read addr 200.
- Required response: data_out=0 at once while in reset; after release, the read of addr 200 returns 144.
REQ-031: Random read scenario:
- Stimulus: 20 random addresses with rd=1, wr=0.
- Required response: each data_out equals (2*addr)%256, one cycle after its read edge.
REQ-032: Parameter scenario:
- Stimulus: DEPTH=1000; write then read addr 1010.
- Required response: the write is ignored and data_out=0.
